// File: rtl/idecode_sb_pkg.sv
// Shared decode definitions for idecode_sb: field positions, opcode map,
// decoded-opcode enum and the decode/immediate helper functions.
package idecode_sb_pkg;

  localparam int W_OPC  = 5;
  localparam int W_DOPC = 4;
  localparam int W_CC   = 3;
  localparam int W_IMM  = 16;

  // inst layout: opc[31:27] immf[26] rd[21 +: W_RD] rs[16 +: W_RD] imm[15:0]
  localparam int OFF_OPC  = 27;
  localparam int BIT_IMMF = 26;
  localparam int OFF_RD   = 21;
  localparam int OFF_RS   = 16;

  localparam logic [W_OPC-1:0] OPC_ADD = 5'd0;
  localparam logic [W_OPC-1:0] OPC_SUB = 5'd1;
  localparam logic [W_OPC-1:0] OPC_AND = 5'd2;
  localparam logic [W_OPC-1:0] OPC_OR  = 5'd3;
  localparam logic [W_OPC-1:0] OPC_XOR = 5'd4;
  localparam logic [W_OPC-1:0] OPC_SHL = 5'd5;
  localparam logic [W_OPC-1:0] OPC_LDH = 5'd6;
  localparam logic [W_OPC-1:0] OPC_CMP = 5'd7;
  localparam logic [W_OPC-1:0] OPC_JMP = 5'd8;

  typedef enum logic [W_DOPC-1:0] {
    DNOP  = 4'd0,
    DADD  = 4'd1,
    DSUB  = 4'd2,
    DAND  = 4'd3,
    DOR   = 4'd4,
    DXOR  = 4'd5,
    DSHL  = 4'd6,
    DLDH  = 4'd7,
    DCMP  = 4'd8,
    DJUMP = 4'd9
  } dopc_e;

  function automatic dopc_e decode_ope(input logic [W_OPC-1:0] opc);
    case (opc)
      OPC_ADD: return DADD;
      OPC_SUB: return DSUB;
      OPC_AND: return DAND;
      OPC_OR:  return DOR;
      OPC_XOR: return DXOR;
      OPC_SHL: return DSHL;
      OPC_LDH: return DLDH;
      OPC_CMP: return DCMP;
      OPC_JMP: return DJUMP;
      default: return DNOP;
    endcase
  endfunction

  // Logical ops zero-extend, LDH loads the upper half, everything else sign-extends.
  function automatic logic [31:0] expand_imm(input logic [W_OPC-1:0] opc,
                                             input logic [W_IMM-1:0] imm);
    case (opc)
      OPC_AND, OPC_OR, OPC_XOR: return {16'h0, imm};
      OPC_LDH:                  return {imm, 16'h0};
      default:                  return {{16{imm[W_IMM-1]}}, imm};
    endcase
  endfunction

  function automatic logic wb_required(input logic [W_OPC-1:0] opc);
    dopc_e d;
    d = decode_ope(opc);
    return !(d == DNOP || d == DCMP || d == DJUMP);
  endfunction

endpackage

// File: rtl/idecode_sb_regscoreboard.sv
// Register busy-bit scoreboard: one set port, one clear port, a flush mask
// and two combinational read ports. Set wins over a same-cycle clear.
module regscoreboard #(
  parameter int NREG = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_v,
  input  logic [$clog2(NREG)-1:0] set_num,
  input  logic                    clr_v,
  input  logic [$clog2(NREG)-1:0] clr_num,
  input  logic [NREG-1:0]         flush_mask,
  input  logic [$clog2(NREG)-1:0] ra_num,
  input  logic [$clog2(NREG)-1:0] rb_num,
  output logic                    ra_busy,
  output logic                    rb_busy
);
  localparam int W_RD = $clog2(NREG);

  logic [NREG-1:0] busy;

  for (genvar g = 0; g < NREG; g++) begin : g_bit
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        busy[g] <= 1'b0;
      else if (set_v && set_num == W_RD'(g))
        busy[g] <= 1'b1;
      else if ((clr_v && clr_num == W_RD'(g)) || flush_mask[g])
        busy[g] <= 1'b0;
    end
  end

  assign ra_busy = busy[ra_num];
  assign rb_busy = busy[rb_num];

endmodule

// File: rtl/idecode_sb.sv
// Instruction decode stage with register scoreboard interlock and a
// two-entry (output + skid) FIFO toward EX.
module idecode_sb
  import idecode_sb_pkg::*;
#(
  parameter int WORD = 32,
  parameter int ADDR = 32,
  parameter int NREG = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    v_i,
  output logic                    stall_o,
  input  logic [WORD-1:0]         inst_i,
  input  logic [ADDR-1:0]         origaddr_i,
  input  logic                    flush_i,
  output logic [$clog2(NREG)-1:0] r0_num_o,
  output logic [$clog2(NREG)-1:0] r1_num_o,
  input  logic [WORD-1:0]         r0_data_i,
  input  logic [WORD-1:0]         r1_data_i,
  input  logic                    wbk_v_i,
  input  logic [$clog2(NREG)-1:0] wbk_num_i,
  output logic                    v_o,
  input  logic                    stall_i,
  output logic [WORD-1:0]         src_o,
  output logic [WORD-1:0]         dest_o,
  output logic                    wb_o,
  output logic [$clog2(NREG)-1:0] rd_num_o,
  output logic [W_DOPC-1:0]       dopc_o,
  output logic [W_OPC-1:0]        opc_o,
  output logic [ADDR-1:0]         origaddr_o,
  output logic [W_CC-1:0]         cc_o
);
  localparam int W_RD = $clog2(NREG);

  typedef struct packed {
    logic [WORD-1:0] src;
    logic [WORD-1:0] dest;
    logic            wb;
    logic [W_RD-1:0] rd;
    dopc_e           dopc;
    logic [W_OPC-1:0] opc;
    logic [ADDR-1:0] addr;
    logic [W_CC-1:0] cc;
  } ent_t;

  logic [W_RD-1:0]  rd_f, rs_f;
  logic [W_OPC-1:0] opc_f;
  logic [W_IMM-1:0] imm_f;
  logic             immf;
  logic             rd_busy, rs_busy, hazard, full, accept, pop;
  logic [1:0]       cnt;
  ent_t             e0, e1, ne;
  logic [NREG-1:0]  flush_mask;
  logic             unused_inst;

  assign rd_f  = inst_i[OFF_RD +: W_RD];
  assign rs_f  = inst_i[OFF_RS +: W_RD];
  assign opc_f = inst_i[OFF_OPC +: W_OPC];
  assign imm_f = inst_i[W_IMM-1:0];
  assign immf  = inst_i[BIT_IMMF];
  assign unused_inst = ^inst_i;

  assign r0_num_o = rd_f;
  assign r1_num_o = rs_f;

  // Scoreboard is read from registered state only, so a same-cycle wbk does not bypass.
  assign hazard  = v_i & (rd_busy | (~immf & rs_busy));
  assign stall_o = hazard | full;
  assign accept  = v_i & ~stall_o & ~flush_i;
  assign v_o     = (cnt != 2'd0);
  assign pop     = v_o & ~stall_i;

  always_comb begin
    ne      = '0;
    ne.src  = immf ? WORD'(expand_imm(opc_f, imm_f)) : r1_data_i;
    ne.dest = r0_data_i;
    ne.wb   = wb_required(opc_f);
    ne.rd   = rd_f;
    ne.dopc = decode_ope(opc_f);
    ne.opc  = opc_f;
    ne.addr = origaddr_i;
    ne.cc   = rd_f[W_CC-1:0];
  end

  // Only writes owned by entries still held here are released on flush.
  always_comb begin
    flush_mask = '0;
    if (flush_i) begin
      if (cnt != 2'd0 && e0.wb) flush_mask[e0.rd] = 1'b1;
      if (cnt == 2'd2 && e1.wb) flush_mask[e1.rd] = 1'b1;
    end
  end

  regscoreboard #(.NREG(NREG)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_v      (accept & ne.wb),
    .set_num    (rd_f),
    .clr_v      (wbk_v_i),
    .clr_num    (wbk_num_i),
    .flush_mask (flush_mask),
    .ra_num     (rd_f),
    .rb_num     (rs_f),
    .ra_busy    (rd_busy),
    .rb_busy    (rs_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 2'd0;
      full <= 1'b0;
      e0   <= '0;
      e1   <= '0;
    end else if (flush_i) begin
      cnt  <= 2'd0;
      full <= 1'b0;
    end else begin
      case (cnt)
        2'd0: if (accept) begin
          e0  <= ne;
          cnt <= 2'd1;
        end
        2'd1: begin
          if (accept && pop) begin
            e0 <= ne;
          end else if (accept) begin
            e1   <= ne;
            cnt  <= 2'd2;
            full <= 1'b1;
          end else if (pop) begin
            cnt <= 2'd0;
          end
        end
        default: if (pop) begin
          e0   <= e1;
          cnt  <= 2'd1;
          full <= 1'b0;
        end
      endcase
    end
  end

  assign src_o      = e0.src;
  assign dest_o     = e0.dest;
  assign wb_o       = e0.wb;
  assign rd_num_o   = e0.rd;
  assign dopc_o     = e0.dopc;
  assign opc_o      = e0.opc;
  assign origaddr_o = e0.addr;
  assign cc_o       = e0.cc;

endmodule

// File: tb/tb_idecode_sb.sv
// Directed self-checking bench for idecode_sb: issue, RAW interlock, skid
// buffering, immediates, flush and mid-run reset.
module tb_idecode_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v_i = 1'b0;
  logic        stall_o;
  logic [31:0] inst_i = '0;
  logic [31:0] origaddr_i = '0;
  logic        flush_i = 1'b0;
  logic [3:0]  r0_num_o, r1_num_o;
  logic [31:0] r0_data_i, r1_data_i;
  logic        wbk_v_i = 1'b0;
  logic [3:0]  wbk_num_i = '0;
  logic        v_o;
  logic        stall_i = 1'b0;
  logic [31:0] src_o, dest_o;
  logic        wb_o;
  logic [3:0]  rd_num_o;
  logic [3:0]  dopc_o;
  logic [4:0]  opc_o;
  logic [31:0] origaddr_o;
  logic [2:0]  cc_o;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, OR = 5'd3, XOR = 5'd4, LDH = 5'd6, JMP = 5'd8;

  always #5 clk = ~clk;

  // Register file model: contents encode the register number.
  assign r0_data_i = 32'h1000_0000 | {28'h0, r0_num_o};
  assign r1_data_i = 32'h2000_0000 | {28'h0, r1_num_o};

  idecode_sb dut (
    .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o), .inst_i(inst_i),
    .origaddr_i(origaddr_i), .flush_i(flush_i), .r0_num_o(r0_num_o),
    .r1_num_o(r1_num_o), .r0_data_i(r0_data_i), .r1_data_i(r1_data_i),
    .wbk_v_i(wbk_v_i), .wbk_num_i(wbk_num_i), .v_o(v_o), .stall_i(stall_i),
    .src_o(src_o), .dest_o(dest_o), .wb_o(wb_o), .rd_num_o(rd_num_o),
    .dopc_o(dopc_o), .opc_o(opc_o), .origaddr_o(origaddr_o), .cc_o(cc_o)
  );

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic immf,
                                     input logic [3:0] rd, input logic [3:0] rs,
                                     input logic [15:0] imm);
    return {opc, immf, 1'b0, rd, 1'b0, rs, imm};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] addr);
    v_i = v;
    inst_i = inst;
    origaddr_i = addr;
    #1;
  endtask

  task automatic wbk(input logic [3:0] n);
    wbk_v_i = 1'b1;
    wbk_num_i = n;
    tick();
    wbk_v_i = 1'b0;
  endtask

  task automatic test_reset;
    drive(1'b1, mk(ADD, 1'b0, 4'd1, 4'd2, 16'h0), 32'h10);
    tick(); tick();
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL rst_v: got %0b want 0", v_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b want 0", stall_o); end
    checks++; if (src_o !== 32'h0 || dest_o !== 32'h0) begin errors++; $display("FAIL rst_data: src %h dest %h want 0", src_o, dest_o); end
    checks++; if (rd_num_o !== 4'd0 || dopc_o !== 4'd0 || origaddr_o !== 32'h0) begin errors++; $display("FAIL rst_fields: rd %0d dopc %0d addr %h want 0", rd_num_o, dopc_o, origaddr_o); end
    drive(1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    drive(1'b1, mk(ADD, 1'b0, 4'd1, 4'd2, 16'h0), 32'h100);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall1: got %0b want 0", stall_o); end
    tick();
    checks++; if (v_o !== 1'b1 || rd_num_o !== 4'd1) begin errors++; $display("FAIL b2b_first: v %0b rd %0d want 1/1", v_o, rd_num_o); end
    checks++; if (src_o !== 32'h2000_0002 || dest_o !== 32'h1000_0001) begin errors++; $display("FAIL b2b_data: src %h dest %h want 20000002/10000001", src_o, dest_o); end
    checks++; if (dopc_o !== 4'd1 || wb_o !== 1'b1 || opc_o !== ADD || origaddr_o !== 32'h100) begin errors++; $display("FAIL b2b_dec: dopc %0d wb %0b opc %0d addr %h", dopc_o, wb_o, opc_o, origaddr_o); end
    drive(1'b1, mk(ADD, 1'b0, 4'd3, 4'd4, 16'h0), 32'h104);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall2: got %0b want 0", stall_o); end
    tick();
    checks++; if (v_o !== 1'b1 || rd_num_o !== 4'd3 || origaddr_o !== 32'h104) begin errors++; $display("FAIL b2b_second: v %0b rd %0d addr %h want 1/3/104", v_o, rd_num_o, origaddr_o); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0b want 0", v_o); end
    wbk(4'd1); wbk(4'd3);
  endtask

  task automatic test_jump_decode;
    drive(1'b1, mk(JMP, 1'b0, 4'd13, 4'd0, 16'h0), 32'h200);
    tick();
    checks++; if (dopc_o !== 4'd9 || cc_o !== 3'd5 || wb_o !== 1'b0) begin errors++; $display("FAIL jmp_dec: dopc %0d cc %0d wb %0b want 9/5/0", dopc_o, cc_o, wb_o); end
    drive(1'b1, mk(ADD, 1'b0, 4'd0, 4'd13, 16'h0), 32'h204);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL jmp_nobusy: got %0b want 0", stall_o); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_raw;
    drive(1'b1, mk(ADD, 1'b0, 4'd1, 4'd2, 16'h0), 32'h300);
    tick();
    drive(1'b1, mk(SUB, 1'b0, 4'd5, 4'd1, 16'h0), 32'h304);
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL raw_stall: got %0b want 1", stall_o); end
    tick();
    checks++; if (v_o !== 1'b0 || stall_o !== 1'b1) begin errors++; $display("FAIL raw_hold: v %0b stall %0b want 0/1", v_o, stall_o); end
    wbk_v_i = 1'b1; wbk_num_i = 4'd1; #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL raw_nobypass: got %0b want 1", stall_o); end
    tick();
    wbk_v_i = 1'b0; #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL raw_release: got %0b want 0", stall_o); end
    tick();
    checks++; if (v_o !== 1'b1 || rd_num_o !== 4'd5 || dopc_o !== 4'd2 || src_o !== 32'h2000_0001) begin errors++; $display("FAIL raw_issue: v %0b rd %0d dopc %0d src %h", v_o, rd_num_o, dopc_o, src_o); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    wbk(4'd5);
  endtask

  task automatic test_fifo;
    stall_i = 1'b1;
    drive(1'b1, mk(ADD, 1'b0, 4'd2, 4'd3, 16'h0), 32'h400);
    tick();
    drive(1'b1, mk(XOR, 1'b0, 4'd6, 4'd7, 16'h0), 32'h404);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL fifo_stall2: got %0b want 0", stall_o); end
    tick();
    drive(1'b1, mk(OR, 1'b0, 4'd8, 4'd9, 16'h0), 32'h408);
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL fifo_full: got %0b want 1", stall_o); end
    tick();
    checks++; if (v_o !== 1'b1 || rd_num_o !== 4'd2 || origaddr_o !== 32'h400) begin errors++; $display("FAIL fifo_head: v %0b rd %0d addr %h want 1/2/400", v_o, rd_num_o, origaddr_o); end
    stall_i = 1'b0; #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL fifo_indep: got %0b want 1", stall_o); end
    tick();
    checks++; if (rd_num_o !== 4'd6 || origaddr_o !== 32'h404 || dopc_o !== 4'd5) begin errors++; $display("FAIL fifo_second: rd %0d addr %h dopc %0d", rd_num_o, origaddr_o, dopc_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL fifo_unstall: got %0b want 0", stall_o); end
    tick();
    checks++; if (v_o !== 1'b1 || rd_num_o !== 4'd8 || origaddr_o !== 32'h408) begin errors++; $display("FAIL fifo_third: v %0b rd %0d addr %h", v_o, rd_num_o, origaddr_o); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL fifo_nodup: got %0b want 0", v_o); end
    wbk(4'd2); wbk(4'd6); wbk(4'd8);
  endtask

  task automatic test_imm;
    drive(1'b1, mk(ADD, 1'b0, 4'd7, 4'd0, 16'h0), 32'h500);
    tick();
    drive(1'b1, mk(OR, 1'b1, 4'd4, 4'd7, 16'h8001), 32'h504);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL imm_nostall: got %0b want 0", stall_o); end
    tick();
    checks++; if (src_o !== 32'h0000_8001 || dopc_o !== 4'd4) begin errors++; $display("FAIL imm_zext: src %h dopc %0d want 00008001/4", src_o, dopc_o); end
    drive(1'b1, mk(ADD, 1'b1, 4'd5, 4'd7, 16'h8001), 32'h508);
    tick();
    checks++; if (src_o !== 32'hFFFF_8001) begin errors++; $display("FAIL imm_sext: got %h want ffff8001", src_o); end
    drive(1'b1, mk(LDH, 1'b1, 4'd9, 4'd7, 16'h1234), 32'h50c);
    tick();
    checks++; if (src_o !== 32'h1234_0000 || dopc_o !== 4'd7) begin errors++; $display("FAIL imm_ldh: src %h dopc %0d want 12340000/7", src_o, dopc_o); end
    drive(1'b1, mk(ADD, 1'b0, 4'd10, 4'd7, 16'h0), 32'h510);
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL imm_reg_rs: got %0b want 1", stall_o); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    wbk(4'd7); wbk(4'd4); wbk(4'd5); wbk(4'd9);
  endtask

  task automatic test_flush;
    drive(1'b1, mk(ADD, 1'b0, 4'd11, 4'd0, 16'h0), 32'h600);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    stall_i = 1'b1;
    drive(1'b1, mk(ADD, 1'b0, 4'd2, 4'd3, 16'h0), 32'h604);
    tick();
    drive(1'b1, mk(ADD, 1'b0, 4'd6, 4'd3, 16'h0), 32'h608);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; stall_i = 1'b0; #1;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL flush_v: got %0b want 0", v_o); end
    drive(1'b1, mk(ADD, 1'b0, 4'd12, 4'd11, 16'h0), 32'h60c);
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL flush_keep11: got %0b want 1", stall_o); end
    drive(1'b1, mk(ADD, 1'b0, 4'd2, 4'd6, 16'h0), 32'h610);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_clr26: got %0b want 0", stall_o); end
    drive(1'b1, mk(ADD, 1'b0, 4'd13, 4'd0, 16'h0), 32'h614);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL flush_noacc: got %0b want 0", v_o); end
    drive(1'b1, mk(ADD, 1'b0, 4'd0, 4'd13, 16'h0), 32'h618);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_noset13: got %0b want 0", stall_o); end
    drive(1'b0, 32'h0, 32'h0);
    wbk(4'd11);
  endtask

  task automatic test_reset_mid;
    stall_i = 1'b1;
    drive(1'b1, mk(ADD, 1'b0, 4'd1, 4'd2, 16'h0), 32'h700);
    tick();
    drive(1'b1, mk(ADD, 1'b0, 4'd3, 4'd4, 16'h0), 32'h704);
    tick();
    drive(1'b1, mk(ADD, 1'b0, 4'd5, 4'd1, 16'h0), 32'h708);
    checks++; if (stall_o !== 1'b1 || v_o !== 1'b1) begin errors++; $display("FAIL rmid_pre: stall %0b v %0b want 1/1", stall_o, v_o); end
    rst = 1'b1; #1;
    checks++; if (v_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL rmid_async: v %0b stall %0b want 0/0", v_o, stall_o); end
    tick();
    rst = 1'b0; stall_i = 1'b0;
    drive(1'b1, mk(ADD, 1'b0, 4'd3, 4'd1, 16'h0), 32'h70c);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rmid_sbclr: got %0b want 0", stall_o); end
    tick();
    checks++; if (v_o !== 1'b1 || rd_num_o !== 4'd3 || origaddr_o !== 32'h70c) begin errors++; $display("FAIL rmid_issue: v %0b rd %0d addr %h", v_o, rd_num_o, origaddr_o); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    wbk(4'd3);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_jump_decode();
    test_raw();
    test_fifo();
    test_imm();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/idecode_sb.md
IDECODE_SB -- requirements
Module: idecode_sb

Interface
REQ-001 SHALL have parameters: WORD, default 32, datapath width; ADDR, default 32, instruction address width; NREG, default 16, architectural register count (power of two, W_RD = clog2(NREG)).
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- v_i  in  1  instruction valid from IF.
- stall_o  out  1  IF must hold inst_i/origaddr_i.
- inst_i  in  WORD  instruction.
- origaddr_i  in  ADDR  instruction address.
- flush_i  in  1  discard all instructions held in this stage.
- r0_num_o  out  W_RD  rd field to RF (combinational).
- r1_num_o  out  W_RD  rs field to RF (combinational).
- r0_data_i  in  WORD  RF read data for rd.
- r1_data_i  in  WORD  RF read data for rs.
- wbk_v_i  in  1  WB stage retires a register write.
- wbk_num_i  in  W_RD  register retired.
- v_o  out  1  decoded entry valid to EX.
- stall_i  in  1  EX cannot accept.
- src_o  out  WORD  rs data, or expanded imm when immf.
- dest_o  out  WORD  rd data.
- wb_o  out  1  writeback required.
- rd_num_o  out  W_RD  rd number.
- dopc_o  out  W_DOPC  decoded opcode.
- opc_o  out  W_OPC  raw opcode.
- origaddr_o  out  ADDR  instruction address.
- cc_o  out  W_CC  condition code (low bits of rd).

Function
REQ-003 SHALL keep a scoreboard of NREG busy bits, one per register with a write in flight.
REQ-004 hazard SHALL be 1 when v_i=1 and any of the following holds: busy[rd] (rd read as dest, RAW/WAW); or !immf and busy[rs].
REQ-005 A busy bit cleared by wbk_v_i in the same cycle SHALL still count as busy; there is no bypass, and issue occurs the next cycle at the earliest.
REQ-006 stall_o SHALL equal hazard | full, where full is a registered flag (count==2); stall_o SHALL NOT depend on stall_i.
REQ-007 Accept SHALL occur when v_i & ~stall_o & ~flush_i; an accepted instruction SHALL be decoded and captured with operand data in the cycle it is accepted.
REQ-008 SHALL hold up to 2 entries (output register plus one skid entry), FIFO order; v_o=1 iff count>=1, and the outputs SHALL show the oldest entry.
REQ-009 Pop SHALL occur when v_o & ~stall_i; simultaneous push and pop SHALL keep the count unchanged; push with count==2 SHALL be impossible.
REQ-010 On accept with wb=1, the stage SHALL set busy[rd] at the clock edge; if wbk clears the same register in that cycle, the set SHALL win.
REQ-011 On wbk_v_i, the stage SHALL clear busy[wbk_num_i]; wbk_v_i for a non-busy register SHALL be ignored.
REQ-012 On flush_i, the stage SHALL drop all held entries (count=0, v_o=0 next cycle), clear the busy bits owned by dropped entries with wb=1, and accept nothing that cycle.
REQ-013 Latency SHALL be 1 cycle from accept to v_o when the stage is empty and stall_i=0.
REQ-014 When immf=1, src SHALL be expand_imm(opc, imm); otherwise src SHALL be r1_data_i.

Reset
REQ-015 While rst=1, the stage SHALL hold v_o=0, count=0, full=0, all busy bits=0, and all data outputs at 0; stall_o SHALL be 0 because v_i is ignored.
REQ-016 Reset mid-operation SHALL discard entries and the scoreboard without issuing a wbk.

Structure
REQ-017 Field positions, W_OPC/W_DOPC/W_CC/W_IMM, DJUMP, decode_ope, expand_imm and wb_required SHALL stay in the shared params/decode includes.
REQ-018 The scoreboard SHALL be a sub-module, regscoreboard (set, clear, flush-mask, two read ports).

Verification
REQ-019 Independent add r1,r2 then add r3,r4 with stall_i=0 -> v_o on consecutive cycles, stall_o=0.
REQ-020 add r1,r2 accepted, then sub r5,r1 -> stall_o=1 until the cycle after wbk_v_i=1/wbk_num_i=1, then issue.
REQ-021 stall_i=1 held with 3 back-to-back valid instructions -> 2 buffered, stall_o=1 on the 3rd; release stall_i -> FIFO order preserved, no loss or duplication.
REQ-022 Immediate instruction with rs field = busy r7 -> no stall; src_o = expand_imm value.
REQ-023 Two buffered wb entries (r2, r6), flush_i pulse -> v_o=0 next cycle, busy[2]=busy[6]=0, busy bits from earlier instructions preserved.
REQ-024 Assert rst with count=2 and busy bits set -> v_o=0 and scoreboard cleared immediately; first instruction after release issues without stall.
